// File: rtl/b_type_branch_unit_pkg.sv
// rtl/b_type_branch_unit_pkg.sv - shared RV32I branch constants, funct3 enum and immediate helper
package rv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } branch_funct3_e;

  // B-type immediates are 13-bit signed byte offsets; widen to a 32-bit address delta
  function automatic logic [31:0] sext13to32(input logic [12:0] v);
    return {{19{v[12]}}, v};
  endfunction

endpackage

// File: rtl/b_type_branch_unit_if.sv
// rtl/b_type_branch_unit_if.sv - execute-stage branch operand/result bundle
interface b_type_branch_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [12:0]      imm;
  logic [31:0]      in1;
  logic [31:0]      in2;
  logic [31:0]      pc;
  logic [31:0]      iaddr;
  logic             taken;
  logic             illegal;
  logic             misaligned;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Decode/issue side: supplies the instruction and observes the resolution
  modport master (
    output opcode, funct3, imm, in1, in2, pc,
    input  iaddr, taken, illegal, misaligned, branch_cnt, taken_cnt
  );

  // Branch unit side
  modport slave (
    input  opcode, funct3, imm, in1, in2, pc,
    output iaddr, taken, illegal, misaligned, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/b_type_branch_unit_cmp.sv
// rtl/b_type_branch_unit_cmp.sv - funct3-selected operand comparator
module branch_cmp
  import rv_pkg::*;
(
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  logic [2:0]  funct3_i,
  output logic        cond_o,
  output logic        illegal_o
);

  // Evaluate the branch condition; funct3 codes 2 and 3 have no branch meaning
  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     cond_o = (in1_i == in2_i);
      BNE:     cond_o = (in1_i != in2_i);
      BLT:     cond_o = ($signed(in1_i) <  $signed(in2_i));
      BGE:     cond_o = ($signed(in1_i) >= $signed(in2_i));
      BLTU:    cond_o = (in1_i <  in2_i);
      BGEU:    cond_o = (in1_i >= in2_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/b_type_branch_unit.sv
// rtl/b_type_branch_unit.sv - RV32I B-type branch resolution with performance counters
module b_type_branch_unit #(
  parameter int         CNT_W      = 32,
  parameter logic [6:0] OPC_BRANCH = 7'b1100011
) (
  input  logic                   clk,
  input  logic                   rst,
  b_type_branch_unit_if.slave    bus
);
  import rv_pkg::*;

  logic             is_br;
  logic             cond;
  logic             f3_illegal;
  logic             illegal;
  logic             taken;
  logic             misaligned;
  logic [31:0]      target;
  logic [31:0]      seq_addr;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] taken_cnt_d;

  branch_cmp u_cmp (
    .in1_i     (bus.in1),
    .in2_i     (bus.in2),
    .funct3_i  (bus.funct3),
    .cond_o    (cond),
    .illegal_o (f3_illegal)
  );

  // Resolve the next fetch address; flags never alter iaddr
  always_comb begin
    is_br      = (bus.opcode == OPC_BRANCH);
    illegal    = is_br & f3_illegal;
    taken      = is_br & cond & ~illegal;
    target     = bus.pc + sext13to32(bus.imm);
    seq_addr   = bus.pc + 32'd4;
    misaligned = taken & (target[1:0] != 2'b00);
  end

  // Next counter values: count every legal branch and every taken one
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (is_br && !illegal) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (taken)             taken_cnt_d  = taken_cnt_q + CNT_W'(1);
  end

  // Counter registers clear immediately on reset and wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Drive the result bundle
  always_comb begin
    bus.iaddr      = taken ? target : seq_addr;
    bus.taken      = taken;
    bus.illegal    = illegal;
    bus.misaligned = misaligned;
    bus.branch_cnt = branch_cnt_q;
    bus.taken_cnt  = taken_cnt_q;
  end

endmodule

// File: tb/tb_b_type_branch_unit.sv
// tb/tb_b_type_branch_unit.sv - self-checking bench for b_type_branch_unit
module tb_b_type_branch_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  logic [31:0] exp_branch;
  logic [31:0] exp_taken;

  typedef struct {
    logic [31:0] iaddr;
    logic        taken;
    logic        illegal;
    logic        misaligned;
    logic        counted;
  } exp_t;

  b_type_branch_unit_if #(.CNT_W(32)) bus ();

  b_type_branch_unit #(.CNT_W(32), .OPC_BRANCH(7'b1100011)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [12:0] imm, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc);
    exp_t  e;
    bit    br;
    bit    c;
    int    off;
    logic [31:0] tgt;
    br  = (op == 7'b1100011);
    off = (imm >= 13'h1000) ? int'(imm) - 8192 : int'(imm);
    tgt = pc + off;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = (int'(a) < int'(b));
      3'd5: c = (int'(a) >= int'(b));
      3'd6: c = (longint'(a) < longint'(b));
      3'd7: c = (longint'(a) >= longint'(b));
      default: c = 1'b0;
    endcase
    e.illegal    = br && (f3 == 3'd2 || f3 == 3'd3);
    e.taken      = br && c && !e.illegal;
    e.iaddr      = e.taken ? tgt : pc + 32'd4;
    e.misaligned = e.taken && (tgt % 4 != 0);
    e.counted    = br && !e.illegal;
    return e;
  endfunction

  // Reference counters tracking every rising edge the DUT sees
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      exp_branch <= 0;
      exp_taken  <= 0;
    end else begin
      e = model(bus.opcode, bus.funct3, bus.imm, bus.in1, bus.in2, bus.pc);
      if (e.counted) exp_branch <= exp_branch + 1;
      if (e.taken)   exp_taken  <= exp_taken + 1;
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [12:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.imm    = imm;
    bus.in1    = a;
    bus.in2    = b;
    bus.pc     = pc;
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (bus.branch_cnt !== 32'd0 || bus.taken_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.branch_cnt, bus.taken_cnt);
    end
    drive(7'b1100011, 3'd0, 13'h010, 32'd1, 32'd1, 32'h1000);
    vectors++;
    if (bus.taken !== 1'b1 || bus.iaddr !== 32'h1010) begin
      errors++;
      $display("FAIL reset_comb: got taken=%b iaddr=%h want 1/00001010", bus.taken, bus.iaddr);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.branch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: got %0d want 0", bus.branch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_beq();
    @(negedge clk);
    drive(7'b1100011, 3'd0, 13'h010, 32'd1, 32'd1, 32'h1000);
    vectors++;
    if (bus.iaddr !== 32'h1010 || bus.taken !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken: got iaddr=%h taken=%b want 00001010/1", bus.iaddr, bus.taken);
    end
    drive(7'b1100011, 3'd0, 13'h010, 32'd1, 32'd2, 32'h1000);
    vectors++;
    if (bus.iaddr !== 32'h1004 || bus.taken !== 1'b0) begin
      errors++;
      $display("FAIL beq_not: got iaddr=%h taken=%b want 00001004/0", bus.iaddr, bus.taken);
    end
  endtask

  task automatic test_bne_blt_bge();
    logic [2:0]  f3s [6]  = '{3'd1, 3'd1, 3'd4, 3'd4, 3'd5, 3'd5};
    logic [31:0] b2s [6]  = '{32'd2, 32'd1, 32'd4, 32'd0, 32'd4, 32'd0};
    logic        tks [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] want;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(7'b1100011, f3s[i], 13'h1FF0, 32'd1, b2s[i], 32'h2000);
      want = tks[i] ? 32'h1FF0 : 32'h2004;
      vectors++;
      if (bus.taken !== tks[i] || bus.iaddr !== want) begin
        errors++;
        $display("FAIL cmp_f3_%0d_in2_%0d: got taken=%b iaddr=%h want %b/%h",
                 f3s[i], b2s[i], bus.taken, bus.iaddr, tks[i], want);
      end
    end
  endtask

  task automatic test_signed_unsigned();
    @(negedge clk);
    drive(7'b1100011, 3'd4, 13'h010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC);
    vectors++;
    if (bus.taken !== 1'b1 || bus.iaddr !== 32'h0000000C) begin
      errors++;
      $display("FAIL blt_signed: got taken=%b iaddr=%h want 1/0000000c", bus.taken, bus.iaddr);
    end
    drive(7'b1100011, 3'd6, 13'h010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC);
    vectors++;
    if (bus.taken !== 1'b0 || bus.iaddr !== 32'h00000000) begin
      errors++;
      $display("FAIL bltu_wrap: got taken=%b iaddr=%h want 0/00000000", bus.taken, bus.iaddr);
    end
    drive(7'b1100011, 3'd7, 13'h010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC);
    vectors++;
    if (bus.taken !== 1'b1) begin
      errors++;
      $display("FAIL bgeu: got taken=%b want 1", bus.taken);
    end
  endtask

  task automatic test_non_branch();
    @(negedge clk);
    drive(7'b0000000, 3'd0, 13'h010, 32'd5, 32'd5, 32'h3000);
    vectors++;
    if (bus.iaddr !== 32'h3004 || bus.taken !== 1'b0 || bus.illegal !== 1'b0 || bus.misaligned !== 1'b0) begin
      errors++;
      $display("FAIL non_branch: got iaddr=%h t=%b i=%b m=%b want 00003004/0/0/0",
               bus.iaddr, bus.taken, bus.illegal, bus.misaligned);
    end
    drive(7'b1100011, 3'd2, 13'h010, 32'd5, 32'd5, 32'h3000);
    vectors++;
    if (bus.illegal !== 1'b1 || bus.iaddr !== 32'h3004 || bus.taken !== 1'b0) begin
      errors++;
      $display("FAIL illegal_f3: got i=%b iaddr=%h t=%b want 1/00003004/0",
               bus.illegal, bus.iaddr, bus.taken);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive(7'b1100011, 3'd0, 13'h002, 32'd7, 32'd7, 32'h100);
    vectors++;
    if (bus.misaligned !== 1'b1 || bus.iaddr !== 32'h102) begin
      errors++;
      $display("FAIL misaligned: got m=%b iaddr=%h want 1/00000102", bus.misaligned, bus.iaddr);
    end
  endtask

  task automatic test_counters();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(7'b1100011, 3'd0, 13'h010, 32'd1, 32'd1, 32'h1000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive(7'b1100011, 3'd1, 13'h010, 32'd1, 32'd1, 32'h1000);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.branch_cnt !== 32'd8 || bus.taken_cnt !== 32'd5) begin
      errors++;
      $display("FAIL cnt_8_5: got %0d/%0d want 8/5", bus.branch_cnt, bus.taken_cnt);
    end
    @(negedge clk);
    drive(7'b1100011, 3'd0, 13'h010, 32'd1, 32'd1, 32'h1000);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.branch_cnt !== 32'd0 || bus.taken_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_rst: got %0d/%0d want 0/0", bus.branch_cnt, bus.taken_cnt);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.branch_cnt !== 32'd0 || bus.taken_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_hold: got %0d/%0d want 0/0", bus.branch_cnt, bus.taken_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.branch_cnt !== 32'd1 || bus.taken_cnt !== 32'd1) begin
      errors++;
      $display("FAIL first_after_rst: got %0d/%0d want 1/1", bus.branch_cnt, bus.taken_cnt);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [12:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    for (int i = 0; i < 200; i++) begin
      op  = ($urandom_range(0, 3) != 0) ? 7'b1100011 : 7'($urandom);
      f3  = 3'($urandom);
      imm = 13'($urandom);
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
      pc  = $urandom;
      @(negedge clk);
      drive(op, f3, imm, a, b, pc);
      e = model(op, f3, imm, a, b, pc);
      vectors++;
      if (bus.iaddr !== e.iaddr || bus.taken !== e.taken ||
          bus.illegal !== e.illegal || bus.misaligned !== e.misaligned) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 bus.iaddr, bus.taken, bus.illegal, bus.misaligned,
                 e.iaddr, e.taken, e.illegal, e.misaligned);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.branch_cnt !== exp_branch || bus.taken_cnt !== exp_taken) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                 bus.branch_cnt, bus.taken_cnt, exp_branch, exp_taken);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.imm    = 13'd0;
    bus.in1    = 32'd0;
    bus.in2    = 32'd0;
    bus.pc     = 32'd0;
    test_reset();
    test_beq();
    test_bne_blt_bge();
    test_signed_unsigned();
    test_non_branch();
    test_misaligned();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
